// File: rtl/serial_word_rx.sv
// serial_word_rx: framed serial-to-parallel receiver with a single-word output
// holding register, ready/valid handshake and a sticky overrun flag.
module serial_word_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic                         CLK,
    input  logic                         clr,
    input  logic                         ser_in,
    input  logic                         ser_en,
    input  logic                         frame,
    input  logic                         out_ready,
    input  logic                         err_clr,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    output logic                         busy,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
    output logic                         overrun
);
    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            st_q, st_d;
    logic [WIDTH-1:0]  sr_q, sr_d, data_q, data_d, shifted, first;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d, ovr_q, ovr_d, done;

    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            st_q    <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], ser_in} : {ser_in, sr_q[WIDTH-1:1]};
        first   = MSB_FIRST ? WIDTH'(ser_in) : {ser_in, {(WIDTH-1){1'b0}}};
        st_d    = st_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        // frame restarts a word from any state, discarding any partial word
        if (ser_en && frame) begin
            st_d  = SHIFT;
            sr_d  = first;
            cnt_d = CW'(1);
        end else if (ser_en && st_q == SHIFT) begin
            sr_d = shifted;
            if (cnt_q == CW'(WIDTH-1)) begin
                done  = 1'b1;
                st_d  = IDLE;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        data_d  = (done && (!valid_q || out_ready)) ? shifted : data_q;
        valid_d = (done && (!valid_q || out_ready)) ? 1'b1 : (valid_q && out_ready) ? 1'b0 : valid_q;
        ovr_d   = (done && valid_q && !out_ready) || (ovr_q && !err_clr);
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = (st_q == SHIFT);
    assign bit_cnt   = cnt_q;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: directed and random stimulus for both bit orders, checked
// against a bit-queue reference model of the receiver.
module tb_serial_word_rx;
    localparam int W = 4;

    logic CLK = 1'b0, clr = 1'b0;
    logic ser_in = 1'b0, ser_en = 1'b0, frame = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
    logic [W-1:0] data_m, data_l;
    logic valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
    logic [2:0] cnt_m, cnt_l;

    int checks = 0, errors = 0;

    // reference model state
    int q[$];
    bit act = 0, mv = 0, mo = 0;
    logic [W-1:0] md_m = '0, md_l = '0;

    always #5 CLK = ~CLK;

    serial_word_rx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .CLK(CLK), .clr(clr), .ser_in(ser_in), .ser_en(ser_en), .frame(frame),
        .out_ready(out_ready), .err_clr(err_clr), .out_data(data_m), .out_valid(valid_m),
        .busy(busy_m), .bit_cnt(cnt_m), .overrun(ovr_m));

    serial_word_rx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .CLK(CLK), .clr(clr), .ser_in(ser_in), .ser_en(ser_en), .frame(frame),
        .out_ready(out_ready), .err_clr(err_clr), .out_data(data_l), .out_valid(valid_l),
        .busy(busy_l), .bit_cnt(cnt_l), .overrun(ovr_l));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".data_msb"}, 32'(data_m), 32'(md_m));
        chk({tag, ".data_lsb"}, 32'(data_l), 32'(md_l));
        chk({tag, ".valid"}, 32'(valid_m), 32'(mv));
        chk({tag, ".valid_lsb"}, 32'(valid_l), 32'(mv));
        chk({tag, ".busy"}, 32'(busy_m), 32'(act));
        chk({tag, ".bit_cnt"}, 32'(cnt_m), 32'(q.size()));
        chk({tag, ".overrun"}, 32'(ovr_m), 32'(mo));
    endtask

    task automatic model(input logic en, fr, b, rdy, ec);
        bit done = 0;
        logic [W-1:0] wm = '0, wl = '0;
        if (en) begin
            if (fr) begin
                q = {int'(b)};
                act = 1;
            end else if (act) begin
                q.push_back(int'(b));
                if (q.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        wm[W-1-i] = q[i][0];
                        wl[i] = q[i][0];
                    end
                    done = 1;
                    q = {};
                    act = 0;
                end
            end
        end
        if (ec) mo = 0;
        if (done && (!mv || rdy)) begin
            md_m = wm;
            md_l = wl;
            mv = 1;
        end else if (done) mo = 1;
        else if (mv && rdy) mv = 0;
    endtask

    task automatic step(input logic en, fr, b, rdy, ec);
        ser_en = en; frame = fr; ser_in = b; out_ready = rdy; err_clr = ec;
        @(posedge CLK);
        #1;
        model(en, fr, b, rdy, ec);
        ser_en = 0; frame = 0; ser_in = 0; out_ready = 0; err_clr = 0;
        chk_all("step");
    endtask

    // w is sent in time order w[W-1] first; gap idle cycles after each bit
    task automatic send(input logic [W-1:0] w, input logic rdy, input int gap);
        for (int i = W-1; i >= 0; i--) begin
            step(1, i == W-1, w[i], rdy, 0);
            for (int g = 0; g < gap; g++) step(0, 0, 0, rdy, 0);
        end
    endtask

    task automatic do_reset();
        clr = 0;
        #1;
        q = {}; act = 0; mv = 0; mo = 0; md_m = '0; md_l = '0;
        chk_all("reset");
        #1;
        clr = 1;
    endtask

    initial begin
        #2 do_reset();
        step(1, 0, 1, 0, 0);
        chk("ignore_no_frame.busy", 32'(busy_m), 32'(0));
        send(4'b1011, 0, 0);
        chk("msb_word", 32'(data_m), 32'hb);
        chk("lsb_word", 32'(data_l), 32'hd);
        chk("done.cnt", 32'(cnt_m), 32'(0));
        step(0, 0, 0, 1, 0);
        chk("consume.valid", 32'(valid_m), 32'(0));
        chk("consume.data_kept", 32'(data_m), 32'hb);
        send(4'b1011, 1, 3);
        chk("gap_word", 32'(data_m), 32'hb);
        do_reset();
        send(4'b1011, 0, 0);
        send(4'b0110, 0, 0);
        chk("overrun.data", 32'(data_m), 32'hb);
        chk("overrun.flag", 32'(ovr_m), 32'(1));
        step(0, 0, 0, 1, 0);
        chk("overrun.consume", 32'(valid_m), 32'(0));
        step(0, 0, 0, 0, 1);
        chk("err_clr", 32'(ovr_m), 32'(0));
        send(4'b1111, 0, 0);
        send(4'b0101, 0, 0);
        step(0, 0, 0, 0, 1);
        send(4'b0000, 0, 0);
        chk("ovr_again", 32'(ovr_m), 32'(1));
        // new overrun on the same edge as err_clr keeps the flag set
        for (int i = W-1; i >= 0; i--) step(1, i == W-1, 1'b1, 0, i == 0);
        chk("ovr_wins", 32'(ovr_m), 32'(1));
        do_reset();
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        send(4'b0010, 0, 0);
        chk("restart.data", 32'(data_m), 32'h2);
        chk("restart.ovr", 32'(ovr_m), 32'(0));
        step(0, 0, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        do_reset();
        chk("midword_reset.busy", 32'(busy_m), 32'(0));
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("after_reset.valid", 32'(valid_m), 32'(0));
        send(4'b1001, 0, 0);
        chk("after_reset.data", 32'(data_m), 32'h9);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 1'($urandom),
                 1'($urandom), $urandom_range(0, 7) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_word_rx.md
SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, receive word width in bits (legal 2..32).
REQ-002 SHALL provide parameter MSB_FIRST, default 1; 1 = first received bit lands in out_data[WIDTH-1], 0 = first bit lands in out_data[0].
REQ-003 SHALL provide port CLK  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL provide port clr  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port ser_in  input  1  serial data bit, sampled only when ser_en=1.
REQ-006 SHALL provide port ser_en  input  1  bit strobe; one bit is accepted per CLK edge with ser_en=1.
REQ-007 SHALL provide port frame  input  1  start-of-word marker, qualified by ser_en; it marks ser_in as bit 0 of a new word.
REQ-008 SHALL provide port out_ready  input  1  consumer accepts out_data on an edge where out_valid=1 and out_ready=1.
REQ-009 SHALL provide port err_clr  input  1  synchronous clear of the overrun flag.
REQ-010 SHALL provide port out_data  output  WIDTH  last completed word.
REQ-011 SHALL provide port out_valid  output  1  out_data holds an unconsumed word.
REQ-012 SHALL provide port busy  output  1  a word is partially received (state SHIFT).
REQ-013 SHALL provide port bit_cnt  output  clog2(WIDTH+1)  bits received in the current word.
REQ-014 SHALL provide port overrun  output  1  sticky; a completed word was dropped.

Function
REQ-015 SHALL implement FSM states IDLE and SHIFT; busy=1 exactly in SHIFT.
REQ-016 IDLE: ser_en=1 & frame=1 SHALL capture ser_in as bit 0, set bit_cnt=1, go to SHIFT; ser_en=1 & frame=0 SHALL be ignored.
REQ-017 SHIFT: ser_en=1 & frame=0 SHALL shift ser_in into the internal shift register and increment bit_cnt; ser_en=0 SHALL hold all state (gaps are unlimited).
REQ-018 MSB_FIRST=1 SHALL shift left, with the new bit entering at LSB; MSB_FIRST=0 SHALL shift right, with the new bit entering at MSB.
REQ-019 SHIFT: ser_en=1 & frame=1 SHALL abort the partial word without error, capture ser_in as bit 0, and set bit_cnt=1.
REQ-020 On the edge that accepts bit WIDTH-1, the assembled word SHALL complete; bit_cnt SHALL return to 0 and the FSM SHALL go to IDLE on that edge.
REQ-021 On the completion edge, if out_valid=0 or out_ready=1: out_data SHALL load the word and out_valid SHALL be 1 after that edge; latency is zero extra cycles.
REQ-022 On the completion edge, if out_valid=1 and out_ready=0: the word SHALL be dropped, out_data SHALL be kept unchanged, and overrun SHALL be set to 1.
REQ-023 out_valid=1 & out_ready=1 without completion SHALL clear out_valid; out_data SHALL keep its value.
REQ-024 While out_valid=1 & out_ready=0, out_data SHALL remain stable.
REQ-025 err_clr=1 SHALL clear overrun; a simultaneous new overrun event SHALL win and leave overrun=1.
REQ-026 Reception SHALL continue while out_valid=1, because the shift register is separate from out_data.

Reset
REQ-027 clr=0 SHALL immediately force: state IDLE, shift register 0, bit_cnt 0, out_data 0, out_valid 0, busy 0, overrun 0, with no clock required.
REQ-028 After clr deasserts, the block SHALL ignore input until the first ser_en & frame.
REQ-029 clr asserted mid-word SHALL discard the partial word; no out_valid SHALL follow.

Verification (WIDTH=4 unless stated)
REQ-030 MSB_FIRST=1; frame on bit 0; bits 1,0,1,1 on consecutive edges -> after the 4th edge out_valid=1, out_data=4'b1011, busy=0, bit_cnt=0.
REQ-031 MSB_FIRST=0; same stimulus -> out_data=4'b1101.
REQ-032 Bits 1,0,1,1 with 3 idle (ser_en=0) cycles between bits -> bit_cnt holds across gaps, then 1,2,3,0; out_data=4'b1011.
REQ-033 out_ready=0; word 1011 then word 0110 -> out_data stays 1011 and overrun=1; out_ready=1 for one edge -> out_valid=0; err_clr=1 -> overrun=0.
REQ-034 frame + bits 1,1, then frame + bits 0,0,1,0 -> out_data=4'b0010 with no overrun; busy stays 1 across the restart.
REQ-035 clr pulsed low after 2 bits -> all outputs 0 at once; a following full frame 1,0,0,1 -> out_data=4'b1001.
